// File: rtl/ripple_add_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : ripple_add_unit_if
//  Purpose  : Operand/strobe and result bundle for ripple_add_unit.
//  Signals  : add_en - capture strobe (master -> slave)
//             inc    - 1 = increment a, 0 = a + b (master -> slave)
//             a, b   - WIDTH-bit operands (master -> slave)
//             sum    - registered WIDTH-bit result (slave -> master)
//             cout   - registered carry-out of the MSB cell (slave -> master)
//             valid  - one-cycle pulse after a capture (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface ripple_add_unit_if #(
    parameter int unsigned WIDTH = 3
);
    logic             add_en;
    logic             inc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             valid;

    modport master (
        output add_en, inc, a, b,
        input  sum, cout, valid
    );

    modport slave (
        input  add_en, inc, a, b,
        output sum, cout, valid
    );
endinterface : ripple_add_unit_if
`default_nettype wire

// File: rtl/ripple_add_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ripple_add_unit
//  Purpose  : Registered ripple-carry adder / incrementer. Bit 0 is a
//             half-adder cell, bits 1..WIDTH-1 are full-adder cells. The
//             result and the MSB carry-out are captured on add_en and held
//             until the next capture; valid pulses the cycle after a capture.
//  Ports    : pclk   - rising-edge clock
//             preset - synchronous active-high reset (wins over add_en)
//             bus    - ripple_add_unit_if.slave (add_en, inc, a, b in;
//                      sum, cout, valid out, all outputs registered)
//  Params   : WIDTH  - operand/result width, 1..16
//  Revision : 1.0 - initial release
// ============================================================================
module ripple_add_unit #(
    parameter int unsigned WIDTH = 3
) (
    input  wire logic          pclk,
    input  wire logic          preset,
    ripple_add_unit_if.slave   bus
);

    // Increment mode forces B to the constant 1 (only bit 0 set).
    localparam logic [WIDTH-1:0] c_inc_b = WIDTH'(1);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    assign w_b = bus.inc ? c_inc_b : bus.b;

    // Each bit cell owns its own carry net; chaining through the previous
    // generate instance keeps the carry path as a plain ripple of scalars.
    genvar i;
    generate
        for (i = 0; i < int'(WIDTH); i++) begin : g_bit
            logic w_c;
            if (i == 0) begin : g_half
                assign w_sum[i] = bus.a[i] ^ w_b[i];
                assign w_c      = bus.a[i] & w_b[i];
            end else begin : g_full
                assign w_sum[i] = bus.a[i] ^ w_b[i] ^ g_bit[i-1].w_c;
                assign w_c      = (bus.a[i] & w_b[i])
                                | (bus.a[i] & g_bit[i-1].w_c)
                                | (w_b[i]   & g_bit[i-1].w_c);
            end
        end : g_bit
    endgenerate

    assign w_cout = g_bit[WIDTH-1].w_c;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else if (bus.add_en) begin
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.sum   = r_sum;
    assign bus.cout  = r_cout;
    assign bus.valid = r_valid;

endmodule : ripple_add_unit
`default_nettype wire

// File: tb/tb_ripple_add_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ripple_add_unit
//  Purpose  : Self-checking bench for ripple_add_unit (WIDTH = 3). Expected
//             results are computed arithmetically when a capture is driven,
//             queued, and compared when the DUT raises valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ripple_add_unit;

    localparam int unsigned WIDTH = 3;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    logic pclk;
    logic preset;

    ripple_add_unit_if #(.WIDTH(WIDTH)) bus ();

    ripple_add_unit #(.WIDTH(WIDTH)) u_dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];
    exp_t r_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic inc_i, input logic [WIDTH-1:0] a_i,
                                   input logic [WIDTH-1:0] b_i);
        logic [WIDTH:0] tot;
        exp_t e;
        tot    = {1'b0, a_i} + (inc_i ? (WIDTH+1)'(1) : {1'b0, b_i});
        e.sum  = tot[WIDTH-1:0];
        e.cout = tot[WIDTH];
        return e;
    endfunction

    // Drive one cycle of inputs, clock it, then check outputs 1 time unit
    // after the edge.
    task automatic step(input string tag, input logic rst_i, input logic en_i,
                        input logic inc_i, input logic [WIDTH-1:0] a_i,
                        input logic [WIDTH-1:0] b_i);
        logic exp_valid;
        exp_t e;
        preset     = rst_i;
        bus.add_en = en_i;
        bus.inc    = inc_i;
        bus.a      = a_i;
        bus.b      = b_i;
        exp_valid  = en_i && !rst_i;
        if (exp_valid) sb_q.push_back(model(inc_i, a_i, b_i));
        @(posedge pclk);
        #1;
        if (rst_i) begin
            r_hold = '0;
            sb_q.delete();
        end
        chk({tag, ".valid"}, 32'(bus.valid), 32'(exp_valid));
        if (bus.valid === 1'b1) begin
            chk({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
                e      = sb_q.pop_front();
                r_hold = e;
            end
        end
        chk({tag, ".sum"},  32'(bus.sum),  32'(r_hold.sum));
        chk({tag, ".cout"}, 32'(bus.cout), 32'(r_hold.cout));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        r_hold = '0;
        preset = 1'b1;
        bus.add_en = 1'b0;
        bus.inc    = 1'b0;
        bus.a      = '0;
        bus.b      = '0;

        // Reset held with a capture request: must stay cleared.
        step("rst0", 1'b1, 1'b1, 1'b0, 3'd5, 3'd0);
        step("rst1", 1'b1, 1'b1, 1'b0, 3'd5, 3'd0);
        step("rel",  1'b0, 1'b0, 1'b0, 3'd5, 3'd0);
        step("rel2", 1'b0, 1'b0, 1'b1, 3'd6, 3'd1);

        // Increment, then hold.
        step("inc2",  1'b0, 1'b1, 1'b1, 3'd2, 3'd5);
        step("hold3", 1'b0, 1'b0, 1'b0, 3'd7, 3'd7);

        // Wrap-around and recovery.
        step("inc7", 1'b0, 1'b1, 1'b1, 3'd7, 3'd0);
        step("inc0", 1'b0, 1'b1, 1'b1, 3'd0, 3'd6);

        // Add mode with and without overflow.
        step("add56", 1'b0, 1'b1, 1'b0, 3'd5, 3'd6);
        step("add12", 1'b0, 1'b1, 1'b0, 3'd1, 3'd2);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 64; i++) begin
            step("sweep", 1'b0, 1'b1, 1'b0, 3'(i >> 3), 3'(i));
        end

        // Inputs toggling with add_en low have no effect.
        for (int i = 0; i < 5; i++) begin
            step("ign", 1'b0, 1'b0, 1'(i), 3'($urandom_range(7)), 3'($urandom_range(7)));
        end

        // Reset in the middle of a continuous capture stream.
        for (int i = 0; i < 7; i++) begin
            step("mid", (i == 3) ? 1'b1 : 1'b0, 1'b1, 1'b1, 3'(i + 3), 3'd0);
        end
        step("tail", 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ripple_add_unit
`default_nettype wire

// File: doc/ripple_add_unit.md
Name: ripple_add_unit

Overview:
- Registered ripple-carry adder/incrementer built from two bit-cell types: a half-adder cell for bit 0 and full-adder cells for bits 1..WIDTH-1.
- Serves as the counter-advance datapath for APB peripheral wait-state counters and general small-width add/increment use.
- Bit 0 has no carry-in.
- Result and carry-out are captured on a strobe and held until the next strobe.

Parameters:
- WIDTH, 3, operand/result width in bits; legal range 1..16 (WIDTH=1 means a single half-adder cell).

Ports:
- pclk  input  1  rising-edge clock.
- preset  input  1  synchronous active-high reset.
- add_en  input  1  capture strobe; result registered on the pclk edge where add_en=1.
- inc  input  1  1 = increment mode (B operand forced to 1, i.e. b[0]=1 and b[WIDTH-1:1]=0); 0 = add mode (B = b).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored when inc=1.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out of the MSB cell (overflow / wrap indicator).
- valid  output  1  one-cycle pulse, high in the cycle after a capture.

Behaviour:
- Half-adder cell: S = A xor B; Cout = A and B.
- Full-adder cell: S = A xor B xor Cin; Cout = (A and B) or (A and Cin) or (B and Cin).
- Chain structure:
  - Bit 0 is a half-adder on a[0] and B[0].
  - Bit i (i ≥ 1) is a full-adder on a[i], B[i] and the carry out of bit i-1.
  - cout is the carry out of bit WIDTH-1.
- Combinational result is {carry, S} = a + B, computed modulo 2^(WIDTH+1); there is no external carry-in.
- Registers update only on the pclk rising edge:
  - preset=1: sum=0, cout=0, valid=0. Reset has priority over add_en.
  - preset=0 and add_en=1: sum and cout take the combinational result of the current a, B; valid=1.
  - preset=0 and add_en=0: sum and cout hold; valid=0.
- Latency: 1 cycle from the add_en sample to the visible sum, cout and valid.
- Back-to-back strobes: each cycle captures new operands; valid stays high continuously.
- Wrap-around: increment of all-ones gives sum=0, cout=1. Add-mode overflow gives sum = low WIDTH bits, cout=1.
- Reset asserted in the same cycle as add_en: the capture is discarded and outputs are 0 the next cycle.
- Reset released: the first capture occurs only on a later edge with add_en=1.
- Inputs a, b and inc may change freely when add_en=0 and have no effect.
- No latches, no delays, no combinational path from the inputs to any output.

Test Plan:
- Reset: preset=1 for 2 cycles with add_en=1, a=5 -> sum=0, cout=0, valid=0 throughout. Release -> values unchanged until the next add_en.
- Increment (WIDTH=3): inc=1, a=2, add_en pulse -> next cycle sum=3, cout=0, valid=1. Following cycle valid=0, sum holds at 3.
- Wrap: inc=1, a=7 -> sum=0, cout=1. Then inc=1, a=0 -> sum=1, cout=0.
- Add mode: inc=0, a=5, b=6 -> sum=3, cout=1; a=1, b=2 -> sum=3, cout=0. Exhaustive sweep of all 64 a/b pairs checks {cout,sum} = a+b with 1-cycle latency.
- Hold and ignore: add_en=0 while toggling a, b and inc every cycle for 5 cycles -> sum, cout and valid unchanged (valid=0).
- Reset mid-stream: add_en=1 every cycle with an incrementing a, preset=1 for one cycle -> outputs 0 the next cycle. Captures resume correctly the cycle after preset returns to 0.
